// File: rtl/spi_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_ctrl
// Description : Frame sequencer for the single-character SPI engine: asserts a
//               chip select, streams TX characters through the engine, returns
//               RX characters, then releases CS. Optional watchdog on the
//               engine handshake when SPI_FRAME_WDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_ctrl #(
    parameter int NCS         = 4,
    parameter int CHAR_NBITS  = 32,
    parameter int LEN_W       = 16,
    parameter int DLY_W       = 4,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                  S_SYSCLK,
    input  logic                  S_RESETN,
    input  logic                  S_ENABLE,
    input  logic                  S_FRAME_GO,
    input  logic [LEN_W-1:0]      S_FRAME_LEN,
    input  logic [1:0]            S_CS_SEL,
    input  logic [DLY_W-1:0]      S_CSBEF,
    input  logic [DLY_W-1:0]      S_CSAFT,
    input  logic                  S_TX_VALID,
    input  logic [CHAR_NBITS-1:0] S_TX_DATA,
    output logic                  S_TX_READY,
    output logic                  S_RX_VALID,
    output logic [CHAR_NBITS-1:0] S_RX_DATA,
    output logic                  S_CHAR_GO,
    input  logic                  S_CHAR_DONE,
    output logic [CHAR_NBITS-1:0] S_WCHAR,
    input  logic [CHAR_NBITS-1:0] S_RCHAR,
    output logic [NCS-1:0]        S_SPI_CS_B,
    output logic                  S_BUSY,
`ifdef SPI_FRAME_WDOG_EN
    output logic                  S_WDOG_ERR,
`endif
    output logic                  S_FRAME_DONE
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOAD  = 3'd2,
        ST_XFER  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t                r_state,      w_state_nxt;
    logic [LEN_W-1:0]      r_remaining,  w_remaining_nxt;
    logic [DLY_W-1:0]      r_dly,        w_dly_nxt;
    logic [DLY_W-1:0]      r_csaft,      w_csaft_nxt;
    logic [NCS-1:0]        r_cs_b,       w_cs_b_nxt;
    logic                  r_tx_ready,   w_tx_ready_nxt;
    logic                  r_rx_valid,   w_rx_valid_nxt;
    logic [CHAR_NBITS-1:0] r_rx_data,    w_rx_data_nxt;
    logic                  r_char_go,    w_char_go_nxt;
    logic [CHAR_NBITS-1:0] r_wchar,      w_wchar_nxt;
    logic                  r_busy,       w_busy_nxt;
    logic                  r_frame_done, w_frame_done_nxt;
    logic [NCS-1:0]        w_cs_dec;
    logic                  w_wdog_trip;
    logic                  w_in_frame;

`ifdef SPI_FRAME_WDOG_EN
    logic [15:0]           r_wdog_cnt,   w_wdog_cnt_nxt;
    logic                  r_wdog_err;
`endif

    // An out-of-range select decodes to no active line; the frame still runs.
    always_comb begin
        w_cs_dec = '1;
        for (int i = 0; i < NCS; i++) begin
            if (S_CS_SEL == 2'(i)) w_cs_dec[i] = 1'b0;
        end
    end

    assign w_in_frame = (r_state != ST_IDLE) && (r_state != ST_DONE);

    always_comb begin
        w_state_nxt      = r_state;
        w_remaining_nxt  = r_remaining;
        w_dly_nxt        = r_dly;
        w_csaft_nxt      = r_csaft;
        w_cs_b_nxt       = r_cs_b;
        w_tx_ready_nxt   = r_tx_ready;
        w_rx_valid_nxt   = 1'b0;
        w_rx_data_nxt    = r_rx_data;
        w_char_go_nxt    = 1'b0;
        w_wchar_nxt      = r_wchar;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;
        w_wdog_trip      = 1'b0;
`ifdef SPI_FRAME_WDOG_EN
        w_wdog_cnt_nxt   = r_wdog_cnt;
`endif

        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (S_FRAME_GO && S_ENABLE) begin
                    w_state_nxt     = ST_SETUP;
                    w_remaining_nxt = S_FRAME_LEN;
                    w_dly_nxt       = S_CSBEF;
                    w_csaft_nxt     = S_CSAFT;
                    w_cs_b_nxt      = w_cs_dec;
                    w_busy_nxt      = 1'b1;
                end
            end
            ST_SETUP: begin
                if (r_dly == '0) begin
                    w_state_nxt    = ST_LOAD;
                    w_tx_ready_nxt = 1'b1;
                end else begin
                    w_dly_nxt = r_dly - DLY_W'(1);
                end
            end
            ST_LOAD: begin
                if (S_TX_VALID) begin
                    w_wchar_nxt    = S_TX_DATA;
                    w_char_go_nxt  = 1'b1;
                    w_tx_ready_nxt = 1'b0;
                    w_state_nxt    = ST_XFER;
`ifdef SPI_FRAME_WDOG_EN
                    w_wdog_cnt_nxt = 16'd0;
`endif
                end
            end
            ST_XFER: begin
                if (S_CHAR_DONE) begin
                    w_rx_data_nxt  = S_RCHAR;
                    w_rx_valid_nxt = 1'b1;
                    if (r_remaining == '0) begin
                        w_state_nxt = ST_HOLD;
                        w_dly_nxt   = r_csaft;
                    end else begin
                        w_remaining_nxt = r_remaining - LEN_W'(1);
                        w_state_nxt     = ST_LOAD;
                        w_tx_ready_nxt  = 1'b1;
                    end
                end else begin
`ifdef SPI_FRAME_WDOG_EN
                    if (r_wdog_cnt == 16'(WDOG_CYCLES - 1)) begin
                        w_wdog_trip = 1'b1;
                    end else begin
                        w_wdog_cnt_nxt = r_wdog_cnt + 16'd1;
                    end
`endif
                end
            end
            ST_HOLD: begin
                if (r_dly == '0) begin
                    w_state_nxt      = ST_DONE;
                    w_cs_b_nxt       = '1;
                    w_busy_nxt       = 1'b0;
                    w_frame_done_nxt = 1'b1;
                end else begin
                    w_dly_nxt = r_dly - DLY_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a coincident character completion.
        if ((w_in_frame && !S_ENABLE) || w_wdog_trip) begin
            w_state_nxt      = ST_IDLE;
            w_cs_b_nxt       = '1;
            w_busy_nxt       = 1'b0;
            w_tx_ready_nxt   = 1'b0;
            w_char_go_nxt    = 1'b0;
            w_rx_valid_nxt   = 1'b0;
            w_rx_data_nxt    = r_rx_data;
            w_frame_done_nxt = 1'b0;
        end
    end

    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            r_state      <= ST_IDLE;
            r_remaining  <= '0;
            r_dly        <= '0;
            r_csaft      <= '0;
            r_cs_b       <= '1;
            r_tx_ready   <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_rx_data    <= '0;
            r_char_go    <= 1'b0;
            r_wchar      <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_remaining  <= w_remaining_nxt;
            r_dly        <= w_dly_nxt;
            r_csaft      <= w_csaft_nxt;
            r_cs_b       <= w_cs_b_nxt;
            r_tx_ready   <= w_tx_ready_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_char_go    <= w_char_go_nxt;
            r_wchar      <= w_wchar_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

`ifdef SPI_FRAME_WDOG_EN
    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            r_wdog_cnt <= 16'd0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_cnt <= w_wdog_cnt_nxt;
            r_wdog_err <= w_wdog_trip;
        end
    end

    assign S_WDOG_ERR = r_wdog_err;
`endif

    assign S_SPI_CS_B   = r_cs_b;
    assign S_TX_READY   = r_tx_ready;
    assign S_RX_VALID   = r_rx_valid;
    assign S_RX_DATA    = r_rx_data;
    assign S_CHAR_GO    = r_char_go;
    assign S_WCHAR      = r_wchar;
    assign S_BUSY       = r_busy;
    assign S_FRAME_DONE = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_ctrl
// Description : Scoreboard bench for spi_frame_ctrl with an engine model.
//               Exercises the watchdog when SPI_FRAME_WDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_ctrl;
    localparam int NCS = 4;
    localparam int CW  = 32;
    localparam int LW  = 16;
    localparam int DW  = 4;
`ifdef SPI_FRAME_WDOG_EN
    localparam int WDOG = 16;
`else
    localparam int WDOG = 65535;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          frame_go = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic [1:0]    cs_sel = '0;
    logic [DW-1:0] csbef = '0;
    logic [DW-1:0] csaft = '0;
    logic          tx_valid = 1'b0;
    logic [CW-1:0] tx_data = '0;
    logic          char_done = 1'b0;
    logic [CW-1:0] rchar = '0;
    logic          tx_ready, rx_valid, char_go, busy, frame_done;
    logic [CW-1:0] rx_data, wchar;
    logic [NCS-1:0] cs_b;
`ifdef SPI_FRAME_WDOG_EN
    logic          wdog_err;
`endif

    spi_frame_ctrl #(
        .NCS(NCS), .CHAR_NBITS(CW), .LEN_W(LW), .DLY_W(DW), .WDOG_CYCLES(WDOG)
    ) dut (
        .S_SYSCLK(clk), .S_RESETN(rst_n), .S_ENABLE(enable),
        .S_FRAME_GO(frame_go), .S_FRAME_LEN(frame_len), .S_CS_SEL(cs_sel),
        .S_CSBEF(csbef), .S_CSAFT(csaft),
        .S_TX_VALID(tx_valid), .S_TX_DATA(tx_data), .S_TX_READY(tx_ready),
        .S_RX_VALID(rx_valid), .S_RX_DATA(rx_data),
        .S_CHAR_GO(char_go), .S_CHAR_DONE(char_done),
        .S_WCHAR(wchar), .S_RCHAR(rchar),
        .S_SPI_CS_B(cs_b), .S_BUSY(busy),
`ifdef SPI_FRAME_WDOG_EN
        .S_WDOG_ERR(wdog_err),
`endif
        .S_FRAME_DONE(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [CW-1:0] q_wchar[$];
    logic [CW-1:0] q_rx[$];
    int            q_setup[$];
    int            q_hold[$];
    logic [NCS-1:0] exp_cs = '1;
    int            eng_lat = 0;
    bit            eng_mute = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        total++;
        bad++;
        $display("FAIL %s (cyc %0d)", nm, cyc);
    endtask

    // Engine response: each character comes back with its low byte inverted.
    function automatic logic [CW-1:0] eng_f(input logic [CW-1:0] x);
        return x ^ 32'h0000_00FF;
    endfunction

    initial begin : engine
        logic [CW-1:0] w;
        int lat;
        forever begin
            @(negedge clk);
            if (char_go && !eng_mute) begin
                w   = wchar;
                lat = (eng_lat > 0) ? eng_lat : int'($urandom_range(1, 8));
                repeat (lat - 1) @(negedge clk);
                rchar     = eng_f(w);
                char_done = 1'b1;
                @(negedge clk);
                char_done = 1'b0;
                rchar     = $urandom;
            end
        end
    end

    initial begin : monitor
        bit prev_busy;
        bit want_setup;
        int rise_cyc;
        int last_rx_cyc;
        prev_busy = 1'b0; want_setup = 1'b0; rise_cyc = 0; last_rx_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy  = 1'b0;
                want_setup = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    rise_cyc   = cyc;
                    want_setup = 1'b1;
                end
                prev_busy = busy;
                if (char_go) begin
                    if (q_wchar.size() == 0) flag("unexpected_char_go");
                    else chk("wchar", wchar, q_wchar.pop_front());
                    chk("cs_at_char_go", cs_b, exp_cs);
                    if (want_setup) begin
                        want_setup = 1'b0;
                        if (q_setup.size() != 0) chk("setup_gap", cyc - rise_cyc, q_setup.pop_front());
                    end
                end
                if (rx_valid) begin
                    if (q_rx.size() == 0) flag("unexpected_rx_valid");
                    else chk("rx_data", rx_data, q_rx.pop_front());
                    last_rx_cyc = cyc;
                end
                if (frame_done) begin
                    if (q_hold.size() == 0) flag("unexpected_frame_done");
                    else chk("hold_gap", cyc - last_rx_cyc, q_hold.pop_front());
                    chk("cs_at_done", cs_b, {NCS{1'b1}});
                    chk("busy_at_done", busy, 1'b0);
                end
            end
        end
    end

    // fixed != 0 gives characters fixed*(i+1); abort_at >= 0 drops enable on
    // that character's completion; wd runs one character with a silent engine.
    task automatic run_frame(input int len, input int sel, input int bef, input int aft,
                             input int stall_at, input int stall_cyc, input int abort_at,
                             input bit busy_go, input logic [CW-1:0] fixed, input bit wd);
        logic [CW-1:0] tx[$];
        int nfeed;
        int t;
        exp_cs = '1;
        if (sel < NCS) exp_cs[sel] = 1'b0;
        nfeed = wd ? 1 : ((abort_at >= 0) ? abort_at + 1 : len + 1);
        for (int i = 0; i < nfeed; i++) begin
            tx.push_back((fixed != 0) ? fixed * CW'(i + 1) : CW'($urandom));
            q_wchar.push_back(tx[i]);
            if (!wd && (abort_at < 0 || i < abort_at)) q_rx.push_back(eng_f(tx[i]));
        end
        q_setup.push_back(bef + 2);
        if (!wd && abort_at < 0) q_hold.push_back(aft + 1);

        frame_go = 1'b1; frame_len = LW'(len); cs_sel = 2'(sel);
        csbef = DW'(bef); csaft = DW'(aft);
        @(negedge clk);
        frame_go = 1'b0; frame_len = LW'($urandom); cs_sel = 2'($urandom);
        csbef = DW'($urandom); csaft = DW'($urandom);
        chk("busy_after_go", busy, 1'b1);
        chk("cs_after_go", cs_b, exp_cs);

        for (int i = 0; i < nfeed; i++) begin
            t = 0;
            while (!tx_ready && t < 400) begin @(negedge clk); t++; end
            if (!tx_ready) begin flag("tx_ready_timeout"); return; end
            if (i == stall_at) begin
                repeat (stall_cyc) begin
                    @(negedge clk);
                    chk("tx_ready_in_stall", tx_ready, 1'b1);
                    chk("cs_in_stall", cs_b, exp_cs);
                end
            end
            tx_valid = 1'b1; tx_data = tx[i];
            @(negedge clk);
            tx_valid = 1'b0; tx_data = $urandom;
            if (i == 0 && busy_go) begin
                frame_go = 1'b1; cs_sel = 2'(sel ^ 1); frame_len = LW'(len + 5);
                @(negedge clk);
                frame_go = 1'b0;
            end
            if (i == abort_at) begin
                repeat (3) @(negedge clk);
                enable = 1'b0;
                @(negedge clk);
                chk("cs_after_abort", cs_b, {NCS{1'b1}});
                chk("busy_after_abort", busy, 1'b0);
                chk("tx_ready_after_abort", tx_ready, 1'b0);
                enable = 1'b1;
                repeat (10) @(negedge clk);
                return;
            end
        end
`ifdef SPI_FRAME_WDOG_EN
        if (wd) begin
            t = 0;
            while (!wdog_err && t < 100) begin @(negedge clk); t++; end
            chk("wdog_latency", t, WDOG);
            chk("cs_after_wdog", cs_b, {NCS{1'b1}});
            chk("busy_after_wdog", busy, 1'b0);
            repeat (5) @(negedge clk);
            return;
        end
`endif
        t = 0;
        while (!frame_done && t < 600) begin @(negedge clk); t++; end
        if (!frame_done) flag("frame_done_timeout");
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        int len, sa;
        repeat (3) @(negedge clk);
        chk("rst_cs", cs_b, {NCS{1'b1}});
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b0);
        chk("rst_char_go", char_go, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_wchar", wchar, '0);
        chk("rst_rx_data", rx_data, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // GO while disabled is ignored
        frame_go = 1'b1;
        @(negedge clk);
        frame_go = 1'b0;
        chk("go_disabled_busy", busy, 1'b0);
        chk("go_disabled_cs", cs_b, {NCS{1'b1}});
        enable = 1'b1;
        @(negedge clk);

        eng_lat = 8;
        run_frame(0, 1, 0, 0, -1, 0, -1, 1'b0, 32'hA5, 1'b0);
        eng_lat = 0;
        run_frame(3, 0, 5, 2, -1, 0, -1, 1'b0, 32'h11, 1'b0);
        run_frame(2, 2, 1, 1, 1, 20, -1, 1'b0, 0, 1'b0);
        eng_lat = 4;
        run_frame(3, 3, 2, 1, -1, 0, 1, 1'b0, 0, 1'b0);
        eng_lat = 0;
        run_frame(1, 3, 0, 3, -1, 0, -1, 1'b0, 0, 1'b0);
        run_frame(2, 1, 3, 2, -1, 0, -1, 1'b1, 0, 1'b0);
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(0, 5);
            sa  = (len > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, len)) : -1;
            run_frame(len, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                      sa, $urandom_range(1, 6), -1, 1'($urandom_range(0, 1)), 0, 1'b0);
        end
`ifdef SPI_FRAME_WDOG_EN
        eng_mute = 1'b1;
        run_frame(0, 2, 1, 1, -1, 0, -1, 1'b0, 0, 1'b1);
        eng_mute = 1'b0;
`endif

        // asynchronous reset in the middle of a frame
        frame_go = 1'b1; cs_sel = 2'd2; csbef = 4'd15; frame_len = 16'd4;
        @(negedge clk);
        frame_go = 1'b0;
        chk("busy_before_async_rst", busy, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cs", cs_b, {NCS{1'b1}});
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_wchar", wchar, '0);
        chk("async_rst_rx_data", rx_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        chk("left_wchar", q_wchar.size(), 0);
        chk("left_rx", q_rx.size(), 0);
        chk("left_done", q_hold.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog_timer
        #2000000;
        flag("global_timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "bench time limit reached");
    end

endmodule
`default_nettype wire
